// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: resets the PLL, waits for a stable lock, then releases
// the downstream reset. Timed-out lock attempts are retried before FAULT.
//
// Ports:
//   refclk      reference clock; all logic is clocked on its rising edge
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock indication (asynchronous to refclk)
//   relock_req  level request to restart the sequence (acted on in RUN/FAULT)
//   pll_rst     active-high reset to the PLL (RESET and FAULT)
//   sys_rst_n   active-low reset for the PLL output domain (released in RUN)
//   ready       high in RUN
//   fault       high in FAULT
//   relock_ack  one-cycle pulse on the first RESET cycle after an accepted relock
//   lost_lock   sticky flag: lock was lost while in RUN
//   retry_cnt   timeout retries taken in the current sequence
//   state       RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic       relock_ack,
    output logic       lost_lock,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int unsigned MAX_A =
        (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX =
        (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_retry;
    logic [3:0]    w_retry_nx;
    logic          r_lost;
    logic          w_lost_nx;
    logic          r_ack;
    logic          w_ack_nx;
    logic          r_sync1;
    logic          r_locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_lost     <= 1'b0;
            r_ack      <= 1'b0;
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
            r_state    <= w_state_nx;
            r_retry    <= w_retry_nx;
            r_lost     <= w_lost_nx;
            r_ack      <= w_ack_nx;
            // One shared counter: restarts on any state change, saturates.
            if (w_state_nx != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_retry_nx = r_retry;
        w_lost_nx  = r_lost;
        w_ack_nx   = 1'b0;
        unique case (r_state)
            S_RESET: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_locked_s) begin
                    w_state_nx = S_STABLE;
                end else if (r_cnt == TMO_LAST) begin
                    if (r_retry == RETRY_LIM) begin
                        w_state_nx = S_FAULT;
                    end else begin
                        w_retry_nx = r_retry + 4'd1;
                        w_state_nx = S_RESET;
                    end
                end
            end
            S_STABLE: begin
                if (!r_locked_s) begin
                    w_state_nx = S_WAIT;
                end else if (r_cnt == STB_LAST) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                // Lock loss and relock may coincide; both effects apply.
                if (!r_locked_s) begin
                    w_lost_nx  = 1'b1;
                    w_retry_nx = '0;
                    w_state_nx = S_RESET;
                end
                if (relock_req) begin
                    w_retry_nx = '0;
                    w_ack_nx   = 1'b1;
                    w_state_nx = S_RESET;
                end
            end
            S_FAULT: begin
                if (relock_req) begin
                    w_retry_nx = '0;
                    w_ack_nx   = 1'b1;
                    w_state_nx = S_RESET;
                end
            end
            default: begin
                w_state_nx = S_RESET;
            end
        endcase
    end

    assign pll_rst    = (r_state == S_RESET) || (r_state == S_FAULT);
    assign sys_rst_n  = (r_state == S_RUN);
    assign ready      = (r_state == S_RUN);
    assign fault      = (r_state == S_FAULT);
    assign relock_ack = r_ack;
    assign lost_lock  = r_lost;
    assign retry_cnt  = r_retry;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: timestamp-based reference model compared every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TMO_C = 20;
    localparam int STB_C = 8;
    localparam int MAX_R = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b1;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic       relock_ack;
    logic       lost_lock;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;
    int ecount = 0;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TMO_C),
        .STABLE_CYCLES(STB_C),
        .MAX_RETRIES  (MAX_R)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .relock_ack(relock_ack),
        .lost_lock (lost_lock),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    always #5 refclk = ~refclk;

    // Edges since reset release; at a falling edge with ecount==k the
    // outputs show the values sampled at edge k ("cycle k").
    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    // Reference model: phase plus the cycle it was entered, lock seen
    // through a two-deep history.
    int m_st = 0;
    int m_ent = 0;
    int m_cyc = 0;
    int m_retry = 0;
    bit m_lost = 1'b0;
    bit m_ack = 1'b0;
    bit m_h0 = 1'b0;
    bit m_h1 = 1'b0;
    int m_age;
    int m_nst;
    bit m_ls;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_ent = 0; m_cyc = 0; m_retry = 0;
            m_lost = 0; m_ack = 0; m_h0 = 0; m_h1 = 0;
        end else begin
            m_ls  = m_h1;
            m_h1  = m_h0;
            m_h0  = pll_locked;
            m_age = m_cyc - m_ent + 1;
            m_nst = m_st;
            m_ack = 0;
            case (m_st)
                0: if (m_age >= RST_C) m_nst = 1;
                1: begin
                    if (m_ls) m_nst = 2;
                    else if (m_age >= TMO_C) begin
                        if (m_retry == MAX_R) m_nst = 4;
                        else begin m_retry++; m_nst = 0; end
                    end
                end
                2: begin
                    if (!m_ls) m_nst = 1;
                    else if (m_age >= STB_C) m_nst = 3;
                end
                3: begin
                    if (!m_ls) begin m_lost = 1; m_retry = 0; m_nst = 0; end
                    if (relock_req) begin m_retry = 0; m_ack = 1; m_nst = 0; end
                end
                4: if (relock_req) begin m_retry = 0; m_ack = 1; m_nst = 0; end
                default: m_nst = 0;
            endcase
            m_cyc++;
            if (m_nst != m_st) begin
                m_st  = m_nst;
                m_ent = m_cyc;
            end
        end
    end

    logic [12:0] c_got;
    logic [12:0] c_exp;

    always @(negedge refclk) begin
        c_got = {state, retry_cnt, lost_lock, relock_ack,
                 fault, ready, sys_rst_n, pll_rst};
        c_exp = {3'(m_st), 4'(m_retry), m_lost, m_ack,
                 m_st == 4, m_st == 3, m_st == 3, m_st == 0 || m_st == 4};
        n_vec++;
        if (c_got !== c_exp) begin
            n_err++;
            $display("FAIL model @cycle %0d: got %h expected %h",
                     ecount, c_got, c_exp);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d",
                     name, ecount, got, exp);
        end
    endtask

    task automatic at_cycle(input int k);
        int guard;
        guard = 0;
        @(negedge refclk);
        while (ecount != k && guard < 500) begin
            @(negedge refclk);
            guard++;
        end
        if (ecount != k) begin
            n_vec++;
            n_err++;
            $display("FAIL at_cycle: got %0d expected %0d", ecount, k);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_ack"}, 32'(relock_ack), 0);
        chk({tag, "_lost"}, 32'(lost_lock), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
    endtask

    initial begin
        repeat (3) @(negedge refclk);
        chk_reset_vals("por");
        rst_n = 1'b1;

        // Lock held: straight to RUN.
        at_cycle(3);  chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_state", 32'(state), 0);
        at_cycle(4);  chk("wait_state", 32'(state), 1);
        at_cycle(5);  chk("stable_state", 32'(state), 2);
        at_cycle(12); chk("stable_end", 32'(state), 2);
        chk("stable_sys", 32'(sys_rst_n), 0);
        at_cycle(13); chk("run_state", 32'(state), 3);
        chk("run_sys", 32'(sys_rst_n), 1);
        chk("run_ready", 32'(ready), 1);

        // Lock loss in RUN.
        at_cycle(20); pll_locked = 1'b0;
        at_cycle(22); chk("loss_sys_before", 32'(sys_rst_n), 1);
        at_cycle(23); chk("loss_sys", 32'(sys_rst_n), 0);
        chk("loss_state", 32'(state), 0);
        chk("loss_lost", 32'(lost_lock), 1);
        pll_locked = 1'b1;
        at_cycle(36); chk("rerun_state", 32'(state), 3);
        chk("rerun_lost", 32'(lost_lock), 1);

        // Relock from RUN, then a lock glitch at STABLE count 5.
        at_cycle(40); relock_req = 1'b1;
        at_cycle(41); chk("rl_state", 32'(state), 0);
        chk("rl_ack", 32'(relock_ack), 1);
        chk("rl_retry", 32'(retry_cnt), 0);
        relock_req = 1'b0;
        at_cycle(42); chk("rl_ack_end", 32'(relock_ack), 0);
        at_cycle(49); pll_locked = 1'b0;
        at_cycle(50); pll_locked = 1'b1;
        at_cycle(51); chk("glitch_stable", 32'(state), 2);
        at_cycle(52); chk("glitch_wait", 32'(state), 1);
        chk("glitch_retry", 32'(retry_cnt), 0);
        at_cycle(53); chk("glitch_stable2", 32'(state), 2);
        at_cycle(60); chk("glitch_stable3", 32'(state), 2);
        at_cycle(61); chk("glitch_run", 32'(state), 3);

        // Reset mid-sequence, then no lock: three attempts and FAULT.
        at_cycle(65);
        #2 rst_n = 1'b0; pll_locked = 1'b0;
        #1 chk_reset_vals("rst2");
        @(negedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        at_cycle(23); chk("to1_state", 32'(state), 1);
        chk("to1_retry", 32'(retry_cnt), 0);
        at_cycle(24); chk("to1_reset", 32'(state), 0);
        chk("to1_retry2", 32'(retry_cnt), 1);
        at_cycle(48); chk("to2_state", 32'(state), 0);
        chk("to2_retry", 32'(retry_cnt), 2);
        at_cycle(60); relock_req = 1'b1;
        at_cycle(62); chk("ign_ack", 32'(relock_ack), 0);
        chk("ign_state", 32'(state), 1);
        at_cycle(63); relock_req = 1'b0;
        at_cycle(71); chk("to3_wait", 32'(state), 1);
        at_cycle(72); chk("fault_state", 32'(state), 4);
        chk("fault_flag", 32'(fault), 1);
        chk("fault_pll_rst", 32'(pll_rst), 1);
        chk("fault_retry", 32'(retry_cnt), 2);
        chk("fault_ready", 32'(ready), 0);

        // Relock from FAULT, lock comes back, reaches RUN.
        at_cycle(80); relock_req = 1'b1;
        at_cycle(81); chk("fr_state", 32'(state), 0);
        chk("fr_ack", 32'(relock_ack), 1);
        chk("fr_retry", 32'(retry_cnt), 0);
        chk("fr_fault", 32'(fault), 0);
        relock_req = 1'b0;
        at_cycle(82); chk("fr_ack_end", 32'(relock_ack), 0);
        pll_locked = 1'b1;
        at_cycle(93); chk("fr_stable", 32'(state), 2);
        at_cycle(94); chk("fr_run", 32'(state), 3);
        chk("fr_ready", 32'(ready), 1);

        // Lock loss and relock in the same RUN cycle.
        at_cycle(100); pll_locked = 1'b0;
        at_cycle(102); relock_req = 1'b1;
        chk("both_pre_lost", 32'(lost_lock), 0);
        chk("both_pre_state", 32'(state), 3);
        at_cycle(103); chk("both_state", 32'(state), 0);
        chk("both_lost", 32'(lost_lock), 1);
        chk("both_ack", 32'(relock_ack), 1);
        relock_req = 1'b0;

        // Async reset in WAIT_LOCK with one retry taken.
        at_cycle(135); chk("mid_state", 32'(state), 1);
        chk("mid_retry", 32'(retry_cnt), 1);
        chk("mid_lost", 32'(lost_lock), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        repeat (2) @(negedge refclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, giving the number of cycles pll_rst is held high per attempt (minimum 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000000, giving the maximum number of WAIT_LOCK cycles per attempt (20 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, giving the number of consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, giving the number of timeout retries allowed before FAULT (maximum 15).
REQ-005 SHALL have port refclk, input, 1 bit: the single clock (50 MHz PLL reference); all logic is clocked on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL locked indication, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1 bit: level request to restart the PLL sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-010 SHALL have port sys_rst_n, output, 1 bit: active-low reset to logic in the PLL output domain.
REQ-011 SHALL have port ready, output, 1 bit: high while in RUN.
REQ-012 SHALL have port fault, output, 1 bit: high while in FAULT.
REQ-013 SHALL have port relock_ack, output, 1 bit: one-cycle acknowledge of an accepted relock_req.
REQ-014 SHALL have port lost_lock, output, 1 bit: sticky flag, set when lock is lost while in RUN.
REQ-015 SHALL have port retry_cnt, output, 4 bits: timeout retries taken in the current sequence.
REQ-016 SHALL have port state, output, 3 bits: FSM state, encoded RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-017 SHALL synchronize pll_locked through two refclk flops; locked_s is the second flop, and only locked_s is used by the FSM.
REQ-018 SHALL use one cycle counter, cleared on every state transition and saturating at its terminal value.
REQ-019 SHALL drive all outputs as Moore decodes of registered state and flags: pll_rst=1 in RESET and FAULT; sys_rst_n=1 only in RUN; ready=(state==RUN); fault=(state==FAULT).
REQ-020 RESET: SHALL occupy exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK: if locked_s=1, SHALL go to STABLE next cycle.
REQ-022 WAIT_LOCK: after LOCK_TIMEOUT cycles with locked_s=0, SHALL go to FAULT if retry_cnt==MAX_RETRIES, else increment retry_cnt and go to RESET.
REQ-023 STABLE: locked_s=0 SHALL return the FSM to WAIT_LOCK with a fresh timeout and no retry_cnt change.
REQ-024 STABLE: after STABLE_CYCLES consecutive cycles with locked_s=1, SHALL go to RUN.
REQ-025 RUN: locked_s=0 SHALL set lost_lock, clear retry_cnt and go to RESET.
REQ-026 FAULT: SHALL hold until relock_req is seen.
REQ-027 relock_req=1 in RUN or FAULT SHALL go to RESET, clear retry_cnt, and pulse relock_ack for exactly the cycle in which the state register is RESET first.
REQ-028 relock_req in RESET, WAIT_LOCK or STABLE SHALL be ignored with no ack; a held request SHALL re-trigger only after RUN or FAULT is reached again.
REQ-029 Simultaneous lock loss and relock_req in RUN: SHALL go to RESET, set lost_lock, and assert relock_ack.
REQ-030 lost_lock SHALL clear only on rst_n.

Reset
REQ-031 While rst_n=0, SHALL asynchronously force: state=RESET, counter=0, retry_cnt=0, sync flops=0, lost_lock=0, relock_ack=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0.
REQ-032 On deassertion, SHALL begin the RESET count on the first refclk edge, including when rst_n is asserted mid-sequence from any state.

Verification (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2; cycle 0 = first edge after rst_n release)
REQ-033 pll_locked held 1: pll_rst=1 for cycles 0-3; WAIT_LOCK at 4; STABLE at 5; RUN and sys_rst_n=1 at cycle 13.
REQ-034 pll_locked held 0: three attempts of 24 cycles; FAULT at cycle 72 with retry_cnt=2, fault=1, pll_rst=1.
REQ-035 In FAULT, pulse relock_req 1 cycle: relock_ack=1 for one cycle, retry_cnt=0, state=RESET; then lock at cycle 5 of the sequence reaches RUN.
REQ-036 In STABLE, drop pll_locked for 1 cycle at STABLE count 5: state returns to WAIT_LOCK and RUN is delayed accordingly; retry_cnt unchanged.
REQ-037 In RUN, drop pll_locked: sys_rst_n=0 three cycles later (sync delay plus transition), lost_lock=1 and stays 1 after re-reaching RUN.
REQ-038 Assert rst_n=0 mid-WAIT_LOCK with retry_cnt=1: all outputs return to reset values immediately, without a clock edge.
